icetap_jtag_master: RTL and testbench
=====================================

ICETAP_JTAG_MASTER -- requirements
Module: icetap_jtag_master

Interface
REQ-001 Parameter: MAX_BITS, default 64, maximum scan length in bits.
REQ-002 Parameter: TCK_DIV, default 2, TCK half-period in scan_clk cycles (>=1).
REQ-003 Port: scan_clk  input  1  sole clock; all logic is rising-edge on scan_clk.
REQ-004 Port: scan_reset_  input  1  synchronous, active-low reset.
REQ-005 Port: cmd_valid  input  1  scan command request.
REQ-006 Port: cmd_ready  output  1  block idle, command accepted when cmd_valid && cmd_ready.
REQ-007 Port: cmd_is_ir  input  1  1 = IR scan, 0 = DR scan.
REQ-008 Port: cmd_len  input  $clog2(MAX_BITS+1)  bits to shift; 0 = TAP reset command.
REQ-009 Port: cmd_data  input  MAX_BITS  TDI data, bit 0 shifted first.
REQ-010 Port: rsp_valid  output  1  one-cycle pulse, scan complete.
REQ-011 Port: rsp_data  output  MAX_BITS  captured TDO, bit 0 = first bit out.
REQ-012 Port: jtag_tck  output  1  TCK to icetap target.
REQ-013 Port: jtag_tms  output  1  TMS.
REQ-014 Port: jtag_tdi  output  1  TDI.
REQ-015 Port: jtag_tdo  input  1  TDO from target.

Function
REQ-016 Each TCK period SHALL be a low phase of TCK_DIV cycles followed by a high phase of TCK_DIV cycles; jtag_tck idles low.
REQ-017 jtag_tms/jtag_tdi SHALL change only on the first cycle of a low phase and hold through the period.
REQ-018 jtag_tdo SHALL be sampled on the scan_clk edge where jtag_tck goes 0->1.
REQ-019 States: INIT_RST, IDLE, SCAN, DONE.
REQ-020 INIT_RST: 5 TCKs with TMS=1 then 1 TCK with TMS=0 (TAP to Run-Test/Idle), then IDLE; entered after every reset.
REQ-021 IDLE: cmd_ready=1; on accept, latch cmd_is_ir, cmd_len, cmd_data; go SCAN; first low phase starts the next cycle.
REQ-022 DR scan TMS sequence, N=cmd_len: 1,0,0, then N shift TCKs (TMS=0 except last =1), then 1,0; total N+5 TCKs.
REQ-023 IR scan: as DR with an extra leading TMS=1 (Select-IR); total N+6 TCKs.
REQ-024 jtag_tdi SHALL carry cmd_data[i] during shift TCK i, 0 in all other TCKs.
REQ-025 TDO sampled at shift TCK i SHALL land in rsp_data[i]; rsp_data[MAX_BITS-1:N] = 0.
REQ-026 cmd_len=0: same sequence as INIT_RST (6 TCKs); rsp_data = 0.
REQ-027 cmd_len > MAX_BITS SHALL be clamped to MAX_BITS.
REQ-028 DONE: lasts one cycle after the final high phase ends (tck low); rsp_valid=1; then IDLE.
REQ-029 rsp_data SHALL hold its value until the next rsp_valid.
REQ-030 cmd_ready=0 in INIT_RST, SCAN, DONE; cmd_valid there SHALL be ignored, no queuing.
REQ-031 No backpressure on rsp; the response is lost if not taken.
REQ-032 Latency with command accepted at cycle 0: rsp_valid at cycle 2*TCK_DIV*T+1, T = TCK count.

Reset
REQ-033 While scan_reset_=0 at a clock edge: state=INIT_RST, jtag_tck=0, jtag_tms=1, jtag_tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, counters=0.
REQ-034 Reset mid-scan SHALL abort the scan with no rsp_valid and rerun INIT_RST.

Verification
REQ-035 Release reset, TCK_DIV=1 -> 6 TCKs, TMS 1,1,1,1,1,0; cmd_ready rises at cycle 13.
REQ-036 DR scan len 8, data 0xA5, TDO model = 8-bit shift register preloaded 0x3C -> 13 TCKs, TDI bits 1,0,1,0,0,1,0,1, rsp_data=0x3C, rsp_valid at cycle 27.
REQ-037 IR scan len 4, data 0x2 -> TMS 1,1,0,0,0,0,0,1,1,0; 10 TCKs.
REQ-038 cmd_len=0 and cmd_len=MAX_BITS+5 -> 6-TCK reset sequence with rsp_data=0, and clamped MAX_BITS scan respectively.
REQ-039 cmd_valid held high through a scan -> exactly one command per cmd_ready window; back-to-back scans start the cycle after DONE.
REQ-040 Reset asserted during shift bit 3, TCK_DIV=3 -> no rsp_valid; INIT_RST replays; tck period 6 cycles.

Source files
------------

// File: rtl/icetap_jtag_master.sv
// JTAG scan master for the icetap target: drives TCK/TMS/TDI from scan_clk,
// walks the TAP through an IR or DR scan per command and returns captured TDO.
module icetap_jtag_master #(
  parameter int MAX_BITS = 64,
  parameter int TCK_DIV  = 2
) (
  input  logic                          scan_clk,
  input  logic                          scan_reset_,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_is_ir,
  input  logic [$clog2(MAX_BITS+1)-1:0] cmd_len,
  input  logic [MAX_BITS-1:0]           cmd_data,
  output logic                          rsp_valid,
  output logic [MAX_BITS-1:0]           rsp_data,
  output logic                          jtag_tck,
  output logic                          jtag_tms,
  output logic                          jtag_tdi,
  input  logic                          jtag_tdo
);

  localparam int LEN_W = $clog2(MAX_BITS + 1);
  localparam int IDX_W = $clog2(MAX_BITS + 7);
  localparam int BIT_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);

  localparam logic [1:0] S_INIT_RST = 2'd0;
  localparam logic [1:0] S_IDLE     = 2'd1;
  localparam logic [1:0] S_SCAN     = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]          state_q, state_d;
  logic                prep_q, prep_d;
  logic                act_q, act_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                tck_q, tck_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic [MAX_BITS-1:0] cap_q, cap_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [MAX_BITS-1:0] rsp_data_q, rsp_data_d;

  logic                is_ir_q;
  logic [LEN_W-1:0]    len_q;
  logic [MAX_BITS-1:0] data_q;
  logic                load;
  logic [LEN_W-1:0]    len_c;

  logic                reset_seq;
  logic [IDX_W-1:0]    base, len_x, total, nxt_idx;
  logic                nxt_shift, cur_shift, nxt_tms, nxt_tdi;
  logic [BIT_W-1:0]    nxt_bit, cur_bit;

  // TMS for TCK index i: a 5x1,0 TAP reset walk, or the DR/IR scan path.
  function automatic logic tms_for(input logic [IDX_W-1:0] i, input logic rs,
                                   input logic ir, input logic [IDX_W-1:0] b,
                                   input logic [IDX_W-1:0] n);
    if (rs)         return (i < IDX_W'(5));
    if (i < b)      return (i == '0) || (ir && (i == IDX_W'(1)));
    if (i < b + n)  return (i == b + n - IDX_W'(1));
    return (i == b + n);
  endfunction

  assign len_c     = (cmd_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : cmd_len;
  assign reset_seq = (state_q == S_INIT_RST) || (len_q == '0);
  assign base      = is_ir_q ? IDX_W'(4) : IDX_W'(3);
  assign len_x     = IDX_W'(len_q);
  assign total     = reset_seq ? IDX_W'(6) : base + len_x + IDX_W'(2);
  assign nxt_idx   = act_q ? idx_q + IDX_W'(1) : '0;

  assign nxt_shift = !reset_seq && (nxt_idx >= base) && (nxt_idx < base + len_x);
  assign cur_shift = !reset_seq && (idx_q >= base) && (idx_q < base + len_x);
  assign nxt_bit   = BIT_W'(nxt_idx - base);
  assign cur_bit   = BIT_W'(idx_q - base);
  assign nxt_tms   = tms_for(nxt_idx, reset_seq, is_ir_q, base, len_x);
  assign nxt_tdi   = nxt_shift ? data_q[nxt_bit] : 1'b0;

  // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    prep_d      = prep_q;
    act_d       = act_q;
    div_d       = div_q;
    idx_d       = idx_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    cap_d       = cap_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    load        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          load    = 1'b1;
          state_d = S_SCAN;
          act_d   = 1'b0;
          prep_d  = 1'b0;
          cap_d   = '0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        // prep_q burns one extra cycle after reset so the first low phase
        // lines up with the one that follows a command accept.
        if (!act_q) begin
          if (prep_q) begin
            prep_d = 1'b0;
          end else begin
            act_d = 1'b1;
            idx_d = nxt_idx;
            div_d = '0;
            tms_d = nxt_tms;
            tdi_d = nxt_tdi;
          end
        end else if (div_q != DIV_LAST) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          if (!tck_q) begin
            tck_d = 1'b1;
            if (cur_shift) cap_d[cur_bit] = jtag_tdo;
          end else begin
            tck_d = 1'b0;
            if (idx_q == total - IDX_W'(1)) begin
              act_d = 1'b0;
              if (state_q == S_INIT_RST) begin
                state_d = S_IDLE;
              end else begin
                state_d     = S_DONE;
                rsp_valid_d = 1'b1;
                rsp_data_d  = cap_q;
              end
            end else begin
              idx_d = nxt_idx;
              tms_d = nxt_tms;
              tdi_d = nxt_tdi;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge scan_clk) begin
    if (!scan_reset_) begin
      state_q     <= S_INIT_RST;
      prep_q      <= 1'b1;
      act_q       <= 1'b0;
      div_q       <= '0;
      idx_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cap_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      prep_q      <= prep_d;
      act_q       <= act_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cap_q       <= cap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // NOTE: the command payload has no reset; it is always loaded on accept before it is read.
  always_ff @(posedge scan_clk) begin
    if (load) begin
      is_ir_q <= cmd_is_ir;
      len_q   <= len_c;
      data_q  <= cmd_data;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign jtag_tck  = tck_q;
  assign jtag_tms  = tms_q;
  assign jtag_tdi  = tdi_q;

endmodule

// File: tb/tb_icetap_jtag_master.sv
// Directed bench for icetap_jtag_master: one TCK_DIV=1 instance for scans,
// one TCK_DIV=3 instance for the mid-scan reset case.
module tb_icetap_jtag_master;

  logic       clk = 1'b0;
  logic       rst1_n, rst3_n;
  logic       cmd_valid1, cmd_valid3, cmd_is_ir;
  logic [3:0] cmd_len;
  logic [7:0] cmd_data;

  logic       cmd_ready1, rsp_valid1, tck1, tms1, tdi1, tdo1;
  logic [7:0] rsp_data1;
  logic       cmd_ready3, rsp_valid3, tck3, tms3, tdi3, tdo3;
  logic [7:0] rsp_data3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icetap_jtag_master #(.MAX_BITS(8), .TCK_DIV(1)) u_dut1 (
    .scan_clk(clk), .scan_reset_(rst1_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_is_ir(cmd_is_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
    .jtag_tck(tck1), .jtag_tms(tms1), .jtag_tdi(tdi1), .jtag_tdo(tdo1));

  icetap_jtag_master #(.MAX_BITS(8), .TCK_DIV(3)) u_dut3 (
    .scan_clk(clk), .scan_reset_(rst3_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_is_ir(cmd_is_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3),
    .jtag_tck(tck3), .jtag_tms(tms3), .jtag_tdi(tdi3), .jtag_tdo(tdo3));

  // TDO model: pattern bit k is presented for the k-th TCK after tdo_off in the current scan.
  int         tck_cnt1 = 0;
  int         base1 = 0;
  int         tdo_off = 3;
  logic [7:0] tdo_pat = 8'h3C;
  int         rel1;
  logic [2:0] tdo_sel;
  assign rel1    = tck_cnt1 - base1;
  assign tdo_sel = 3'(rel1 - tdo_off);
  assign tdo1    = (rel1 >= tdo_off && rel1 < tdo_off + 8) ? tdo_pat[tdo_sel] : 1'b0;
  assign tdo3    = 1'b0;

  logic [63:0] tms_sh1 = '0, tdi_sh1 = '0, tms_sh3 = '0;
  int          tck_cnt3 = 0, cyc = 0, last_rise3 = 0, prev_rise3 = 0;
  int          acc1 = 0, rv3 = 0, glitch1 = 0;
  logic        ptms1 = 1'b1, ptdi1 = 1'b0;

  always @(posedge tck1) begin
    tms_sh1  <= {tms_sh1[62:0], tms1};
    tdi_sh1  <= {tdi_sh1[62:0], tdi1};
    tck_cnt1 <= tck_cnt1 + 1;
  end

  always @(posedge tck3) begin
    tms_sh3    <= {tms_sh3[62:0], tms3};
    tck_cnt3   <= tck_cnt3 + 1;
    prev_rise3 <= last_rise3;
    last_rise3 <= cyc;
  end

  always @(posedge clk) begin
    if (cmd_valid1 && cmd_ready1) acc1 <= acc1 + 1;
    if (rsp_valid3) rv3 <= rv3 + 1;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tck1 && (tms1 !== ptms1 || tdi1 !== ptdi1)) glitch1 <= glitch1 + 1;
    ptms1 <= tms1;
    ptdi1 <= tdi1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one command on dut1; lat = cycles from accept edge to rsp_valid (-1 on timeout).
  task automatic scan1(input logic ir, input logic [3:0] len, input logic [7:0] data,
                       input logic hold, output int lat, output int ntck);
    int b;
    for (int i = 0; i < 100 && !cmd_ready1; i++) @(negedge clk);
    @(negedge clk);
    cmd_is_ir  = ir;
    cmd_len    = len;
    cmd_data   = data;
    cmd_valid1 = 1'b1;
    b          = tck_cnt1;
    base1      = b;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid1 = 1'b0;
    lat = -1;
    for (int k = 1; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid1) begin
        lat = k;
        break;
      end
    end
    ntck = tck_cnt1 - b;
  endtask

  initial begin
    int lat, n, b3, rv_base, a0;
    rst1_n = 1'b0; rst3_n = 1'b0;
    cmd_valid1 = 1'b0; cmd_valid3 = 1'b0;
    cmd_is_ir = 1'b0; cmd_len = '0; cmd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {tck1, tms1, tdi1, cmd_ready1, rsp_valid1}, 5'b01000);
    check("reset_rsp_data", rsp_data1, 8'h00);

    // Reset release: edge after release is cycle 0.
    rst1_n = 1'b1; rst3_n = 1'b1;
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (cmd_ready1) begin
        lat = k;
        break;
      end
    end
    check("init_ready_cycle", lat, 13);
    check("init_tck_count", tck_cnt1, 6);
    check("init_tms", tms_sh1[5:0], 6'b111110);

    // DR scan len 8, data 0xA5, target returns 0x3C.
    tdo_off = 3; tdo_pat = 8'h3C;
    scan1(1'b0, 4'd8, 8'hA5, 1'b0, lat, n);
    check("dr_latency", lat, 27);
    check("dr_tck_count", n, 13);
    check("dr_tms", tms_sh1[12:0], 13'b1000000000110);
    check("dr_tdi", tdi_sh1[12:0], 13'b0001010010100);
    check("dr_rsp", rsp_data1, 8'h3C);
    repeat (5) @(posedge clk);
    #1;
    check("rsp_hold", {rsp_valid1, rsp_data1}, {1'b0, 8'h3C});

    // IR scan len 4, data 0x2; upper response bits must be zero.
    tdo_off = 4;
    scan1(1'b1, 4'd4, 8'h02, 1'b0, lat, n);
    check("ir_latency", lat, 21);
    check("ir_tck_count", n, 10);
    check("ir_tms", tms_sh1[9:0], 10'b1100000110);
    check("ir_tdi", tdi_sh1[9:0], 10'b0000010000);
    check("ir_rsp", rsp_data1, 8'h0C);

    // Length 0 is a TAP reset walk.
    scan1(1'b0, 4'd0, 8'hFF, 1'b0, lat, n);
    check("len0_latency", lat, 13);
    check("len0_tck_count", n, 6);
    check("len0_tms", tms_sh1[5:0], 6'b111110);
    check("len0_tdi", tdi_sh1[5:0], 6'b000000);
    check("len0_rsp", rsp_data1, 8'h00);

    // Length 13 clamps to 8.
    tdo_off = 3; tdo_pat = 8'hC3;
    scan1(1'b0, 4'd13, 8'h96, 1'b0, lat, n);
    check("clamp_latency", lat, 27);
    check("clamp_tck_count", n, 13);
    check("clamp_tdi", tdi_sh1[12:0], 13'b0000110100100);
    check("clamp_rsp", rsp_data1, 8'hC3);
    check("tms_tdi_stable_high", glitch1, 0);

    // cmd_valid held: one accept per ready window, next scan right after DONE.
    a0 = acc1;
    scan1(1'b0, 4'd2, 8'h01, 1'b1, lat, n);
    check("hold_first_latency", lat, 15);
    check("hold_first_rsp", rsp_data1, 8'h03);
    base1 = tck_cnt1;
    @(posedge clk);
    #1;
    check("b2b_ready_after_done", cmd_ready1, 1'b1);
    @(posedge clk);
    #1;
    check("b2b_accepted", cmd_ready1, 1'b0);
    lat = -1;
    for (int k = 1; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid1) begin
        lat = k;
        break;
      end
    end
    cmd_valid1 = 1'b0;
    check("b2b_second_latency", lat, 15);
    check("b2b_accept_count", acc1 - a0, 2);

    // TCK_DIV=3 instance: init walk, then reset during shift bit 3.
    check("div3_init_ready", cmd_ready3, 1'b1);
    check("div3_init_tms", tms_sh3[5:0], 6'b111110);
    @(negedge clk);
    cmd_is_ir = 1'b0; cmd_len = 4'd8; cmd_data = 8'hFF; cmd_valid3 = 1'b1;
    b3 = tck_cnt3;
    rv_base = rv3;
    @(posedge clk);
    #1;
    cmd_valid3 = 1'b0;
    for (int k = 0; k < 500 && (tck_cnt3 - b3) < 7; k++) begin
      @(posedge clk);
      #1;
    end
    check("div3_reached_bit3", tck_cnt3 - b3, 7);
    check("div3_scan_period", last_rise3 - prev_rise3, 6);
    @(negedge clk);
    rst3_n = 1'b0;
    @(posedge clk);
    #1;
    check("div3_reset_outs", {tck3, tms3, cmd_ready3, rsp_valid3}, 4'b0100);
    @(negedge clk);
    rst3_n = 1'b1;
    b3 = tck_cnt3;
    lat = -1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (cmd_ready3) begin
        lat = k;
        break;
      end
    end
    check("div3_reinit_ready_cycle", lat, 37);
    check("div3_reinit_tck_count", tck_cnt3 - b3, 6);
    check("div3_reinit_tms", tms_sh3[5:0], 6'b111110);
    check("div3_reinit_period", last_rise3 - prev_rise3, 6);
    check("div3_no_rsp_after_abort", rv3 - rv_base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
